// File: rtl/mac_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mac_result_fifo
// Purpose  : Output buffer for the sum-of-squares accumulator. Every result
//            the accumulator strobes out is captured into a small
//            first-word-fall-through FIFO and drained through a ready/valid
//            handshake. Two sticky status flags are kept:
//              drop - a sample arrived while the FIFO was full and no pop
//                     was freeing a slot, so the sample was discarded
//              wrap - a sample was smaller than the sample before it,
//                     i.e. the accumulator wrapped around
// Ports    :
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high reset
//   valid_in   in   sample strobe (accumulator valid_out)
//   f_in       in   sample data  (accumulator f)
//   out_ready  in   consumer takes the head entry this cycle
//   clear      in   synchronous clear of drop / wrap
//   out_valid  out  head entry present
//   out_data   out  head entry, combinational from storage
//   count      out  occupancy 0..DEPTH
//   full       out  count == DEPTH
//   empty      out  count == 0
//   drop       out  sticky sample-discarded flag
//   wrap       out  sticky wrap-around flag
// Revision : 1.0 - initial release
// ============================================================================
module mac_result_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_in,
  input  logic [WIDTH-1:0]           f_in,
  input  logic                       out_ready,
  input  logic                       clear,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       drop,
  output logic                       wrap
);

  // Pointer width: DEPTH is a power of two, so the pointers wrap modulo
  // DEPTH simply by overflowing.
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [AW-1:0] c_ptr_one   = AW'(1);
  localparam logic [CW-1:0] c_cnt_one   = CW'(1);
  localparam logic [CW-1:0] c_cnt_zero  = '0;
  localparam logic [CW-1:0] c_cnt_depth = CW'(DEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_prev_f;
  logic             r_prev_seen;
  logic             r_drop;
  logic             r_wrap;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop_set;
  logic w_wrap_set;

  // Status decodes straight from the count register, so no input reaches
  // out_valid / full / empty combinationally.
  assign w_full  = (r_count == c_cnt_depth);
  assign w_empty = (r_count == c_cnt_zero);

  // A pop frees the head slot in the same edge, which lets a push into a
  // full FIFO proceed when the consumer is also taking data.
  assign w_pop      = !w_empty && out_ready;
  assign w_push     = valid_in && (!w_full || w_pop);
  assign w_drop_set = valid_in && w_full && !w_pop;

  // Unsigned compare; equal samples are not a wrap. Tracking applies to
  // every strobed sample, accepted or dropped.
  assign w_wrap_set = valid_in && r_prev_seen && (f_in < r_prev_f);

  // --------------------------------------------------------------------------
  // Storage: intentionally not reset. Writes are suppressed during reset so
  // a sample strobed in the reset cycle never lands in memory.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem[r_wr_ptr] <= f_in;
    end
  end

  // --------------------------------------------------------------------------
  // Pointers and occupancy
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
    end
  end

  // Count is kept as its own register rather than derived from the pointers,
  // which removes the full/empty ambiguity of equal pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Previous-sample tracking for wrap detection (unaffected by clear)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_f    <= '0;
      r_prev_seen <= 1'b0;
    end else if (valid_in) begin
      r_prev_f    <= f_in;
      r_prev_seen <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Sticky flags: a set in the same cycle beats clear.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop <= 1'b0;
    end else if (w_drop_set) begin
      r_drop <= 1'b1;
    end else if (clear) begin
      r_drop <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrap <= 1'b0;
    end else if (w_wrap_set) begin
      r_wrap <= 1'b1;
    end else if (clear) begin
      r_wrap <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // First-word fall-through: the head entry is read directly at the read
  // pointer, so the next entry shows as soon as the pointer moves.
  assign out_data  = r_mem[r_rd_ptr];
  assign out_valid = !w_empty;
  assign count     = r_count;
  assign full      = w_full;
  assign empty     = w_empty;
  assign drop      = r_drop;
  assign wrap      = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_mac_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_result_fifo
// Purpose  : Self-checking bench for mac_result_fifo. A queue-based model
//            tracks the expected FIFO contents and flags; directed scenarios
//            are followed by a randomized run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_result_fifo;

  localparam int WIDTH = 20;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk;
  logic             reset;
  logic             valid_in;
  logic [WIDTH-1:0] f_in;
  logic             out_ready;
  logic             clear;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             drop;
  logic             wrap;

  mac_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .f_in      (f_in),
    .out_ready (out_ready),
    .clear     (clear),
    .out_valid (out_valid),
    .out_data  (out_data),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .drop      (drop),
    .wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model
  int unsigned m_q[$];
  int unsigned m_prev_f;
  bit          m_prev_seen;
  bit          m_drop;
  bit          m_wrap;
  int unsigned m_last_popped;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check the head entry that is about to be
  // consumed, advance the model, then compare all outputs after the edge.
  task automatic cycle(input bit rst, input bit v, input int unsigned d,
                       input bit rdy, input bit clr);
    bit pop, push, dset, wset;
    reset     = rst;
    valid_in  = v;
    f_in      = WIDTH'(d);
    out_ready = rdy;
    clear     = clr;
    #1;
    pop  = (m_q.size() > 0) && rdy;
    push = v && ((m_q.size() < DEPTH) || pop);
    dset = v && (m_q.size() == DEPTH) && !pop;
    wset = v && m_prev_seen && (d < m_prev_f);
    if (!rst && pop) check("pop_data", 32'(out_data), m_q[0]);
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_prev_f    = 0;
      m_prev_seen = 0;
      m_drop      = 0;
      m_wrap      = 0;
    end else begin
      if (pop) m_last_popped = m_q.pop_front();
      if (push) m_q.push_back(d);
      if (v) begin
        m_prev_f    = d;
        m_prev_seen = 1;
      end
      if (dset) m_drop = 1;
      else if (clr) m_drop = 0;
      if (wset) m_wrap = 1;
      else if (clr) m_wrap = 0;
    end
    #1;
    check("count",     32'(count),     m_q.size());
    check("empty",     32'(empty),     32'(m_q.size() == 0));
    check("full",      32'(full),      32'(m_q.size() == DEPTH));
    check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    check("drop",      32'(drop),      32'(m_drop));
    check("wrap",      32'(wrap),      32'(m_wrap));
    if (m_q.size() != 0) check("head", 32'(out_data), m_q[0]);
  endtask

  task automatic idle_push(input int unsigned d);
    cycle(0, 1, d, 0, 0);
  endtask

  int unsigned stream[5] = '{441, 1737, 5833, 70858, 74954};

  initial begin
    reset = 1; valid_in = 0; f_in = '0; out_ready = 0; clear = 0;
    m_last_popped = 0;

    // Reset state
    cycle(1, 0, 0, 0, 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_count", 32'(count), 0);

    // Stream of five, then drain
    foreach (stream[i]) idle_push(stream[i]);
    check("stream_count", 32'(count), 5);
    check("stream_head",  32'(out_data), 441);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 1, 0);
      check("stream_order", m_last_popped, stream[i]);
    end
    check("stream_empty", 32'(empty), 1);
    check("stream_flags", {30'd0, drop, wrap}, 0);

    // Fill to DEPTH, overflow by one, drain
    cycle(1, 0, 0, 0, 0);
    for (int i = 1; i <= DEPTH; i++) idle_push(i);
    idle_push(9);
    check("ovf_full",  32'(full),  1);
    check("ovf_count", 32'(count), 8);
    check("ovf_drop",  32'(drop),  1);
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(0, 0, 0, 1, 0);
      check("ovf_drain", m_last_popped, i);
    end

    // Full with simultaneous push and pop
    cycle(1, 0, 0, 0, 0);
    for (int i = 1; i <= DEPTH; i++) idle_push(i);
    cycle(0, 1, 100, 1, 0);
    check("pp_popped", m_last_popped, 1);
    check("pp_count",  32'(count), 8);
    check("pp_drop",   32'(drop),  0);
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 0, 1, 0);
    check("pp_last", m_last_popped, 100);

    // Wrap detection and clear priority
    cycle(1, 0, 0, 0, 0);
    idle_push(1048575);
    idle_push(3);
    check("wrap_set", 32'(wrap), 1);
    cycle(0, 0, 0, 0, 1);
    check("wrap_clr", 32'(wrap), 0);
    idle_push(3);
    check("wrap_equal", 32'(wrap), 0);
    cycle(0, 1, 2, 0, 1);
    check("wrap_set_wins", 32'(wrap), 1);

    // Reset mid-stream with a strobed sample
    cycle(1, 0, 0, 0, 0);
    idle_push(10); idle_push(20); idle_push(30);
    cycle(1, 1, 7, 0, 0);
    check("mrst_count", 32'(count), 0);
    check("mrst_valid", 32'(out_valid), 0);
    idle_push(5);
    check("mrst_data", 32'(out_data), 5);
    check("mrst_wrap", 32'(wrap), 0);

    // Pop on empty
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0);
    check("uflow_count", 32'(count), 0);
    idle_push(42);
    check("uflow_data", 32'(out_data), 42);
    cycle(0, 0, 0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit          r_rst, r_v, r_rdy, r_clr;
      int unsigned r_d;
      r_rst = ($urandom_range(0, 199) == 0);
      r_v   = ($urandom_range(0, 99) < 60);
      r_rdy = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 30 : 75));
      r_clr = ($urandom_range(0, 19) == 0);
      r_d   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7)
                                          : ($urandom() & 32'hFFFFF);
      cycle(r_rst, r_v, r_d, r_rdy, r_clr);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mac_result_fifo.md
# mac_result_fifo

Output buffer for the sum-of-squares accumulator. It captures every `f`/`valid_out` result the accumulator produces and holds them in a small first-word-fall-through FIFO. Results leave through a ready/valid handshake, so a slow consumer does not lose data while the accumulator runs free. It also keeps sticky status flags: one for samples dropped while full, one for accumulator wrap-around (a new result smaller than the previous one).

## Interface
- `WIDTH`, 20, data width; matches accumulator `f`.
- `DEPTH`, 8, number of entries; power of two, at least 2.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `valid_in`  in  1  sample strobe; driven by accumulator `valid_out`.
- `f_in`  in  WIDTH  sample data; driven by accumulator `f`.
- `out_ready`  in  1  consumer accepts the head entry this cycle.
- `clear`  in  1  synchronous clear of `drop` and `wrap`.
- `out_valid`  out  1  head entry present (not empty).
- `out_data`  out  WIDTH  head entry; combinational from storage (FWFT).
- `count`  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `drop`  out  1  sticky: at least one sample was discarded.
- `wrap`  out  1  sticky: a sample was smaller than the preceding sample.

## Operation
- Pop: `out_valid && out_ready`. Read pointer advances; the next entry appears on `out_data` in the same cycle the pointer updates.
- Push: `valid_in && (!full || pop)`. `f_in` is written at the write pointer and the write pointer advances.
- Pointers wrap modulo `DEPTH`. `count` is a separate register: +1 on push only, −1 on pop only, unchanged on push+pop or on neither.
- Full with simultaneous pop: the push is accepted and `count` stays `DEPTH`. There is no drop.
- Full without pop: the sample is discarded and `drop` sets at that edge.
- Empty: no bypass. A push while empty makes `out_valid` high only after the edge.
- `out_ready` while empty is ignored; there is no underflow and pointers hold.
- `out_data` while empty is don't-care.
- Wrap tracking uses `prev_f` (WIDTH) and `prev_seen` (1), both updated on every `valid_in`, whether the sample is accepted or dropped.
  - `wrap` sets when `valid_in && prev_seen && f_in < prev_f`, compared unsigned.
  - Equal values do not set `wrap`.
- Sticky flags:
  - Set condition wins over `clear` in the same cycle.
  - Otherwise `clear` zeroes `drop` and `wrap`.
  - `clear` does not affect FIFO contents, `prev_f`, or `prev_seen`.
- Reset (any cycle, including mid-stream):
  - pointers = 0, `count` = 0, `prev_seen` = 0, `prev_f` = 0, `drop` = 0, `wrap` = 0.
  - Storage contents are not cleared.
  - Reset has priority over all other inputs that cycle; `valid_in` and `out_ready` are ignored.

## Timing
- Reset values: `out_valid`=0, `empty`=1, `full`=0, `count`=0, `drop`=0, `wrap`=0, `out_data` don't-care.
- Latency: a sample pushed at edge N is visible on `out_data`/`out_valid` after edge N, when the FIFO was empty before.
- `count`, `full`, `empty`, `drop`, and `wrap` reflect state after the most recent edge.
- `full`, `empty`, and `out_valid` decode directly from the `count` register.
- Throughput: one push and one pop per cycle, sustained indefinitely.
- Inputs are sampled at the rising edge. The accumulator drives `valid_in`/`f_in` from registers, so there is no combinational path from inputs to `out_valid`.
- `out_data` depends combinationally only on the read pointer and storage, never on `f_in`.

## Test plan
- Reset then stream: `valid_in` pulses with 441, 1737, 5833, 70858, 74954; `out_ready`=0.
  - After the 5th push: `count`=5, `out_data`=441.
  - Then `out_ready`=1 for 5 cycles: `out_data` reads 441, 1737, 5833, 70858, 74954 in order; `empty`=1 afterwards.
  - `drop`=0 and `wrap`=0 throughout.
- Fill to `DEPTH`=8 with values 1..8, `out_ready`=0, then push 9.
  - `full`=1, `count` stays 8, `drop`=1 on the next cycle.
  - Draining returns 1..8; value 9 never appears.
- From full, assert push 100 and pop in the same cycle.
  - Head 1 leaves, `count` stays 8, `drop` unchanged.
  - The last entry drained is 100.
- Wrap: push 1048575 then 3.
  - `wrap`=1 after the second push.
  - Assert `clear` alone: `wrap`=0.
  - Push 3 again (equal): `wrap` stays 0.
  - Push 2 with `clear` in the same cycle: `wrap`=1 (set wins).
- Reset mid-stream: with 3 entries held and `valid_in`=1 with `f_in`=7 during the reset cycle.
  - After the edge: `count`=0, `out_valid`=0, flags 0; the value 7 is not stored.
  - The next push of 5 yields `out_data`=5 with `wrap`=0, because `prev_seen` was cleared.
- Pop on empty: `out_ready`=1 for 4 cycles with no push.
  - `count` stays 0 and pointers hold.
  - A later push of 42 then appears with `out_data`=42.
